// File: rtl/embcpumem_pio_shifter_pkg.sv
// Shared types and default parameters for the PIO-to-74HC595 serialiser.
package embcpumem_pio_shifter_pkg;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_CLK_DIV   = 4;
    localparam bit          DEF_MSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_e;

endpackage

// File: rtl/embcpumem_pio_shifter_if.sv
// Parallel PIO word in, 3-wire shift-register side and status out.
interface embcpumem_pio_shifter_if #(
    parameter int unsigned DATA_W = embcpumem_pio_shifter_pkg::DEF_DATA_W
);
    logic [DATA_W-1:0] in_port;
    logic              sr_ser;
    logic              sr_clk;
    logic              sr_latch;
    logic              busy;
    logic [DATA_W-1:0] shadow;

    modport master (
        output in_port,
        input  sr_ser, sr_clk, sr_latch, busy, shadow
    );

    modport slave (
        input  in_port,
        output sr_ser, sr_clk, sr_latch, busy, shadow
    );
endinterface

// File: rtl/embcpumem_phase_timer.sv
// Loadable down-counter; tc_c_o flags the last cycle of a CLK_DIV-cycle phase.
module embcpumem_phase_timer #(
    parameter int unsigned CLK_DIV = embcpumem_pio_shifter_pkg::DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    output logic tc_c_o
);
    localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);

    logic [CNT_W-1:0] cnt_q;

    // Reload value CLK_DIV-1 gives exactly CLK_DIV cycles up to and including tc.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= CNT_W'(CLK_DIV - 1);
        end else if (load_i) begin
            cnt_q <= CNT_W'(CLK_DIV - 1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign tc_c_o = (cnt_q == '0);

endmodule

// File: rtl/embcpumem_pio_shifter.sv
// Detects changes of the PIO word and shifts it into an external 74HC595,
// keeping a shadow copy of the last word actually latched on the board.
module embcpumem_pio_shifter
    import embcpumem_pio_shifter_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
    parameter bit          MSB_FIRST = DEF_MSB_FIRST
) (
    input  logic                    clk,
    input  logic                    reset,
    embcpumem_pio_shifter_if.slave  pio
);
    localparam int unsigned BIT_W = $clog2(DATA_W + 1);

    state_e            state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] shadow_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic              force_q;
    logic              sr_ser_q;
    logic              sr_clk_q;
    logic              sr_latch_q;
    logic              busy_q;

    logic              start_c;
    logic              tc_c;
    logic              load_c;
    logic              first_bit_c;
    logic              next_bit_c;

    // Timer restarts every idle cycle and at each phase end.
    assign load_c = (state_q == IDLE) || tc_c;

    embcpumem_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (load_c),
        .tc_c_o (tc_c)
    );

    always_comb begin
        start_c     = force_q || (pio.in_port != shadow_q);
        shreg_d     = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
        first_bit_c = MSB_FIRST ? pio.in_port[DATA_W-1] : pio.in_port[0];
        next_bit_c  = MSB_FIRST ? shreg_d[DATA_W-1] : shreg_d[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            word_q     <= '0;
            shadow_q   <= '0;
            bit_cnt_q  <= '0;
            force_q    <= 1'b1;
            sr_ser_q   <= 1'b0;
            sr_clk_q   <= 1'b0;
            sr_latch_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_c) begin
                        shreg_q   <= pio.in_port;
                        word_q    <= pio.in_port;
                        force_q   <= 1'b0;
                        bit_cnt_q <= BIT_W'(DATA_W);
                        sr_ser_q  <= first_bit_c;
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (tc_c) begin
                        sr_clk_q <= 1'b1;
                        state_q  <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (tc_c) begin
                        sr_clk_q  <= 1'b0;
                        bit_cnt_q <= bit_cnt_q - BIT_W'(1);
                        shreg_q   <= shreg_d;
                        if (bit_cnt_q != BIT_W'(1)) begin
                            sr_ser_q <= next_bit_c;
                            state_q  <= SHIFT_LO;
                        end else begin
                            sr_ser_q   <= 1'b0;
                            sr_latch_q <= 1'b1;
                            state_q    <= LATCH;
                        end
                    end
                end
                LATCH: begin
                    if (tc_c) begin
                        sr_latch_q <= 1'b0;
                        busy_q     <= 1'b0;
                        shadow_q   <= word_q;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pio.sr_ser   = sr_ser_q;
    assign pio.sr_clk   = sr_clk_q;
    assign pio.sr_latch = sr_latch_q;
    assign pio.busy     = busy_q;
    assign pio.shadow   = shadow_q;

endmodule

// File: tb/tb_embcpumem_pio_shifter.sv
// Directed bench: default instance (D=4, MSB first) and a D=1, LSB-first instance.
module tb_embcpumem_pio_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a;
    logic reset_b;
    int   errors = 0;
    int   checks = 0;
    int   sel    = 0;

    embcpumem_pio_shifter_if #(.DATA_W(8)) ifa ();
    embcpumem_pio_shifter_if #(.DATA_W(8)) ifb ();

    embcpumem_pio_shifter #(.DATA_W(8), .CLK_DIV(4), .MSB_FIRST(1'b1)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .pio   (ifa.slave)
    );

    embcpumem_pio_shifter #(.DATA_W(8), .CLK_DIV(1), .MSB_FIRST(1'b0)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .pio   (ifb.slave)
    );

    logic       m_ser, m_clk, m_latch, m_busy;
    logic [7:0] m_shadow;
    assign m_ser    = (sel == 0) ? ifa.sr_ser   : ifb.sr_ser;
    assign m_clk    = (sel == 0) ? ifa.sr_clk   : ifb.sr_clk;
    assign m_latch  = (sel == 0) ? ifa.sr_latch : ifb.sr_latch;
    assign m_busy   = (sel == 0) ? ifa.busy     : ifb.busy;
    assign m_shadow = (sel == 0) ? ifa.shadow   : ifb.shadow;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy(input string tag);
        int w = 0;
        while (!m_busy && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, " start"}, 32'(m_busy), 32'd1);
    endtask

    // Follows one transfer from its first busy cycle to the first idle cycle.
    task automatic xfer(input string tag, input logic [7:0] exp_seq, input int exp_busy,
                        input int exp_latch, input logic [7:0] exp_shadow);
        int         busy_n = 0;
        int         latch_n = 0;
        int         nbits = 0;
        logic [7:0] seq = '0;
        logic       prev_clk = 1'b0;
        logic       prev_ser = 1'b0;
        logic       bad = 1'b0;
        wait_busy(tag);
        if (m_busy) begin
            while (m_busy && busy_n < 300) begin
                busy_n++;
                if (m_clk && !prev_clk) begin
                    seq = {seq[6:0], m_ser};
                    nbits++;
                    if (m_ser !== prev_ser) bad = 1'b1;
                end
                if (m_clk && prev_clk && m_ser !== prev_ser) bad = 1'b1;
                if (m_latch) begin
                    latch_n++;
                    if (m_clk || m_ser) bad = 1'b1;
                end
                prev_clk = m_clk;
                prev_ser = m_ser;
                @(negedge clk);
            end
            check({tag, " busy_len"},  32'(busy_n),  32'(exp_busy));
            check({tag, " nbits"},     32'(nbits),   32'd8);
            check({tag, " bits"},      32'(seq),     32'(exp_seq));
            check({tag, " latch_len"}, 32'(latch_n), 32'(exp_latch));
            check({tag, " waveform"},  32'(bad),     32'd0);
            check({tag, " shadow"},    32'(m_shadow), 32'(exp_shadow));
        end
    endtask

    task automatic idle_watch(input string tag, input int n);
        int act = 0;
        repeat (n) begin
            @(negedge clk);
            if (m_busy || m_clk || m_latch) act++;
        end
        check(tag, 32'(act), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rvals [2];
        logic       latch_seen;
        rvals[0] = 8'h3C;
        rvals[1] = 8'h00;

        reset_a = 1'b1;
        reset_b = 1'b1;
        ifa.in_port = 8'h05;
        ifb.in_port = 8'h00;
        repeat (3) @(negedge clk);
        check("a reset outs", 32'({ifa.sr_ser, ifa.sr_clk, ifa.sr_latch, ifa.busy, ifa.shadow}), 32'd0);
        check("b reset outs", 32'({ifb.sr_ser, ifb.sr_clk, ifb.sr_latch, ifb.busy, ifb.shadow}), 32'd0);

        // 1: forced first transfer after reset
        reset_a = 1'b0;
        @(negedge clk);
        check("t1 latency", 32'(m_busy), 32'd1);
        xfer("t1", 8'h05, 68, 4, 8'h05);

        // 2: change while idle, then quiet
        ifa.in_port = 8'hA5;
        @(negedge clk);
        check("t2 latency", 32'(m_busy), 32'd1);
        xfer("t2", 8'hA5, 68, 4, 8'hA5);
        idle_watch("t2 idle", 200);

        // 3: changes during busy collapse to one follow-up of the latest value
        ifa.in_port = 8'h01;
        fork
            xfer("t3a", 8'h01, 68, 4, 8'h01);
            begin
                repeat (10) @(negedge clk);
                ifa.in_port = 8'h02;
                repeat (20) @(negedge clk);
                ifa.in_port = 8'h03;
            end
        join
        xfer("t3b", 8'h03, 68, 4, 8'h03);
        idle_watch("t3 idle", 100);
        check("t3 shadow", 32'(m_shadow), 32'h03);

        // 4: reset at bit 3 aborts without latching, then full retransfer
        for (int i = 0; i < 2; i++) begin
            ifa.in_port = rvals[i];
            @(negedge clk);
            wait_busy("t4");
            latch_seen = m_latch;
            repeat (24) begin
                @(negedge clk);
                latch_seen |= m_latch;
            end
            reset_a = 1'b1;
            @(negedge clk);
            check("t4 reset outs", 32'({ifa.sr_ser, ifa.sr_clk, ifa.sr_latch, ifa.busy, ifa.shadow}), 32'd0);
            latch_seen |= m_latch;
            check("t4 no latch", 32'(latch_seen), 32'd0);
            reset_a = 1'b0;
            xfer("t4 retx", rvals[i], 68, 4, rvals[i]);
        end

        // 6: zero stays idle; 0xFF then back to 0x00 retransfers
        idle_watch("t6 idle", 100);
        ifa.in_port = 8'hFF;
        xfer("t6 ff", 8'hFF, 68, 4, 8'hFF);
        ifa.in_port = 8'h00;
        xfer("t6 00", 8'h00, 68, 4, 8'h00);

        // 5: CLK_DIV=1, LSB first
        sel = 1;
        ifb.in_port = 8'h80;
        reset_b = 1'b0;
        @(negedge clk);
        check("t5 latency", 32'(m_busy), 32'd1);
        xfer("t5", 8'h01, 17, 1, 8'h80);
        idle_watch("t5 idle", 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/embcpumem_pio_shifter.md
# embcpumem_pio_shifter

Serialises the 8-bit PIO output word (`out_port` of the `embcpumem_pio_0` Avalon PIO) into an external 74HC595-style shift register. The block sits directly downstream of the PIO. It detects any change of the parallel word, shifts the word out on a 3-wire interface (data, shift clock, latch), and records the transferred value in a shadow register so software-visible state and board state can be compared.

## Interface
Parameters:
- `DATA_W`, default 8: word width; must be ≥1.
- `CLK_DIV`, default 4: `clk` cycles per half period of `sr_clk`, and length of the latch pulse; must be ≥1.
- `MSB_FIRST`, default 1: 1 shifts bit `DATA_W-1` first; 0 shifts bit 0 first.

Ports:
- `clk`, in, 1: single system clock; all logic on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `in_port`, in, DATA_W: parallel word; connected to PIO `out_port`.
- `sr_ser`, out, 1: serial data to the external register.
- `sr_clk`, out, 1: shift clock; the external register samples on its rising edge.
- `sr_latch`, out, 1: storage-register latch pulse, active high.
- `busy`, out, 1: transfer in progress.
- `shadow`, out, DATA_W: last word fully latched into the external register.

## Operation
- Reset values: `sr_ser`=0, `sr_clk`=0, `sr_latch`=0, `busy`=0, `shadow`=0, state IDLE, `force` flag=1.
  - `force` guarantees that the first word after reset is transferred, even if it equals 0.
- States: IDLE → SHIFT_LO → SHIFT_HI → (repeat per bit) → LATCH → IDLE.
- IDLE:
  - Start a transfer if `in_port != shadow` or `force`=1.
  - On start: capture `in_port` into the shift register, clear `force`, load bit counter = DATA_W, go to SHIFT_LO.
- SHIFT_LO (CLK_DIV cycles):
  - `sr_clk`=0; `sr_ser` = current bit, stable for the whole phase; then go to SHIFT_HI.
- SHIFT_HI (CLK_DIV cycles):
  - `sr_clk`=1; `sr_ser` held; then decrement the bit counter and advance the shift register.
  - Go to SHIFT_LO if bits remain, else to LATCH.
- LATCH (CLK_DIV cycles):
  - `sr_latch`=1, `sr_clk`=0, `sr_ser`=0.
  - On exit: `shadow` ← captured word, go to IDLE.
- `in_port` changes during a transfer are ignored by the shifter. After returning to IDLE the comparison against `shadow` triggers a new transfer of the current value. Intermediate values may be skipped; only the latest value is guaranteed to reach the board.
- `reset` asserted in any state:
  - Aborts the transfer on the next edge and drives outputs to their reset values.
  - The partial word is never latched because `sr_latch` stays 0.
  - `force`=1 ensures a full retransfer.
- Phase timer width: `$clog2(CLK_DIV+1)`. Bit counter width: `$clog2(DATA_W+1)`. No wrap-around is permitted; both counters reload on every phase or transfer start.

## Timing
- All outputs are registered; no combinational path from `in_port` to any output.
- The difference is detected in IDLE on cycle N. `busy`=1 from cycle N+1.
- Let D = CLK_DIV.
- Bit k (k=0 first): `sr_clk` rises at N+1+(2k+1)·D.
- `sr_latch` is high for cycles N+1+2·DATA_W·D … N+(2·DATA_W+1)·D.
- At cycle N+1+(2·DATA_W+1)·D: `busy`=0 and `shadow` holds the new word.
- Default parameters (DATA_W=8, D=4): `busy` is high for 68 cycles. The earliest back-to-back restart is detected on the first IDLE cycle, so IDLE occupies a minimum of 1 cycle between transfers.
- Setup/hold for the external register: `sr_ser` is stable D cycles before and D cycles after each `sr_clk` rising edge.

## Structure
- Shared package `embcpumem_pio_shifter_pkg`:
  - state enum (IDLE, SHIFT_LO, SHIFT_HI, LATCH);
  - default parameter constants.
- One sub-module, `embcpumem_phase_timer`:
  - loadable down-counter with terminal-count pulse, parameterised by CLK_DIV;
  - reused for the LO, HI and LATCH phases.
- Top level holds the FSM, shift register, bit counter, `force` flag and `shadow`.

## Test plan
1. Reset released with `in_port`=0x05 → one transfer. Serial bits on `sr_clk` rises are 0,0,0,0,0,1,0,1. One latch pulse of 4 cycles. `shadow`=0x05 at cycle N+69.
2. `in_port` changed 0x05→0xA5 while idle → bits 1,0,1,0,0,1,0,1; `shadow`=0xA5. Holding `in_port` constant afterwards produces no `sr_clk` activity for 200 cycles.
3. `in_port` goes 0x01→0x02→0x03 during a busy transfer of 0x01 → the first transfer completes with 0x01. Exactly one follow-up transfer of 0x03 follows; `shadow` ends at 0x03.
4. `reset` pulsed at bit 3 of a transfer → outputs return to 0 next cycle with no `sr_latch` pulse. After release, a full transfer of the current `in_port` occurs (also when `in_port`=0x00).
5. CLK_DIV=1, MSB_FIRST=0, `in_port`=0x80 → bits 0,0,0,0,0,0,0,1. `sr_clk` toggles every cycle. `busy` is high for 17 cycles.
6. `in_port`=0x00 after reset → the forced transfer of 0x00 happens once, then stays idle; a write back to 0x00 after a 0xFF transfer triggers a transfer.
